// File: rtl/led_io_pkg.sv
// -----------------------------------------------------------------------------
// led_io_pkg
// Shared definitions for the LED/button I/O blocks.
//   btn_state_t  : button debounce FSM state encoding
//   COUNT_W      : width of the press counter / LED bank
//   ms_to_cycles : converts a millisecond interval to clock cycles (min 1)
// -----------------------------------------------------------------------------
package led_io_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // released and stable
    PRESS_WAIT   = 2'd1,  // candidate press, waiting for stability
    PRESSED      = 2'd2,  // held and stable
    RELEASE_WAIT = 2'd3   // candidate release, waiting for stability
  } btn_state_t;

  // Clamped to 1 so a tiny CLK_FREQ or DEBOUNCE_MS still yields a legal
  // debounce window and a nonzero counter width.
  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    int cycles;
    cycles = (clk_freq / 1000) * ms;
    return (cycles < 1) ? 1 : cycles;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for asynchronous inputs into the clk domain.
//   clk   : destination clock
//   rst_n : synchronous active-low reset, both stages cleared to 0
//   d     : asynchronous input bits (WIDTH)
//   q     : synchronised output bits (WIDTH), second stage
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage1 <= '0;
      q      <= '0;
    end else begin
      // NOTE: non-blocking so q takes the old stage1, giving two real stages.
      stage1 <= d;
      q      <= stage1;
    end
  end

endmodule

// File: rtl/button_counter.sv
// -----------------------------------------------------------------------------
// button_counter
// Synchronises and debounces one push-button and counts confirmed presses.
//   CLK_FREQ    : clock frequency in Hz
//   DEBOUNCE_MS : required stable time in ms
//   clk         : system clock, rising edge
//   rst_n       : synchronous active-low reset
//   btn         : raw asynchronous button, active-high, may bounce
//   clr         : synchronous count clear, active-high (wins over increment)
//   count       : confirmed press count, 8-bit wrapping
//   press_pulse : one-cycle strobe on each count increment
//   pressed     : debounced button level
// Optional feature macro: BUTTON_COUNTER_AUTOREPEAT_EN adds hold-to-repeat
// (first repeat after CLK_FREQ/2 cycles held, then every CLK_FREQ/4 cycles).
// -----------------------------------------------------------------------------
module button_counter
  import led_io_pkg::*;
#(
  parameter int CLK_FREQ    = 25_000_000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               press_pulse,
  output logic               pressed
);

  localparam int              DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int              DB_W      = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYCLES - 1);

  logic            s;
  btn_state_t      state, next_state;
  logic [DB_W-1:0] db_cnt, db_cnt_next;
  logic            press_inc;
  logic            count_inc;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn),
    .q     (s)
  );

  // db_cnt is zeroed on every transition so each wait state starts its
  // stability window fresh; IDLE and PRESSED simply hold that zero.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    next_state  = state;
    db_cnt_next = db_cnt;
    press_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          next_state  = PRESS_WAIT;
          db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          next_state  = IDLE;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          next_state  = PRESSED;
          db_cnt_next = '0;
          press_inc   = 1'b1;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          next_state  = RELEASE_WAIT;
          db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          next_state  = PRESSED;
          db_cnt_next = '0;
        end else if (db_cnt == DB_LAST) begin
          next_state  = IDLE;
          db_cnt_next = '0;
        end else begin
          db_cnt_next = db_cnt + 1'b1;
        end
      end
      default: begin
        next_state  = IDLE;
        db_cnt_next = '0;
      end
    endcase
  end

`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
  localparam logic [31:0] FIRST_LAST  = 32'(CLK_FREQ / 2 - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(CLK_FREQ / 4 - 1);

  logic [31:0] hold_cnt;
  logic        repeat_phase;  // 0: waiting for first repeat, 1: steady repeats
  logic        held;
  logic        repeat_fire;

  // RELEASE_WAIT keeps the timer running so a bounce on release does not
  // restart the repeat schedule.
  assign held        = (state == PRESSED) || (state == RELEASE_WAIT);
  assign repeat_fire = held &&
                       (hold_cnt == (repeat_phase ? REPEAT_LAST : FIRST_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt     <= '0;
      repeat_phase <= 1'b0;
    end else if (press_inc) begin
      hold_cnt     <= '0;
      repeat_phase <= 1'b0;
    end else if (held) begin
      if (repeat_fire) begin
        hold_cnt     <= '0;
        repeat_phase <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign count_inc = press_inc | repeat_fire;
`else
  assign count_inc = press_inc;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      db_cnt      <= '0;
      count       <= '0;
      press_pulse <= 1'b0;
      pressed     <= 1'b0;
    end else begin
      state       <= next_state;
      db_cnt      <= db_cnt_next;
      press_pulse <= count_inc;
      // Registered from next_state so it changes on the same edge as state.
      pressed     <= (next_state == PRESSED) || (next_state == RELEASE_WAIT);
      // clr wins over a coincident increment; the strobe above still fires.
      if (clr) begin
        count <= '0;
      end else if (count_inc) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_button_counter.sv
// -----------------------------------------------------------------------------
// tb_button_counter
// Scoreboard bench for button_counter with CLK_FREQ=1000, DEBOUNCE_MS=5
// (DB_CYCLES=5). Stimulus pushes expected press pulses (cycle + count) and
// expected output levels at given cycles; a monitor samples just after each
// falling edge and compares. cyc = number of rising edges seen so far.
// -----------------------------------------------------------------------------
module tb_button_counter;

  localparam int CLK_FREQ    = 1000;
  localparam int DEBOUNCE_MS = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       clr   = 1'b0;
  logic [7:0] count;
  logic       press_pulse;
  logic       pressed;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_counter #(
    .CLK_FREQ    (CLK_FREQ),
    .DEBOUNCE_MS (DEBOUNCE_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .clr         (clr),
    .count       (count),
    .press_pulse (press_pulse),
    .pressed     (pressed)
  );

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
  } pulse_exp_t;

  typedef enum {SIG_COUNT, SIG_PULSE, SIG_PRESSED} sig_t;

  typedef struct {
    int    cyc;
    sig_t  sig;
    int    val;
    string name;
  } lvl_exp_t;

  pulse_exp_t pulse_q[$];
  lvl_exp_t   lvl_q[$];

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic void expect_pulse(input int at, input int cnt);
    pulse_exp_t e;
    e.cyc = at;
    e.cnt = cnt[7:0];
    pulse_q.push_back(e);
  endfunction

  function automatic void expect_lvl(input int at, input sig_t sig, input int val,
                                     input string name);
    lvl_exp_t e;
    e.cyc  = at;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    lvl_q.push_back(e);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard: the only process that touches checks/failures.
  // ---------------------------------------------------------------------------
  always begin
    @(negedge clk);
    #1;
    if (press_pulse) begin
      if (pulse_q.size() == 0) begin
        check("pulse_unexpected", 1, 0);
      end else begin
        pulse_exp_t e;
        e = pulse_q.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_count", int'(count), int'(e.cnt));
      end
    end
    for (int i = lvl_q.size() - 1; i >= 0; i--) begin
      if (lvl_q[i].cyc == cyc) begin
        case (lvl_q[i].sig)
          SIG_COUNT:   check(lvl_q[i].name, int'(count), lvl_q[i].val);
          SIG_PULSE:   check(lvl_q[i].name, int'(press_pulse), lvl_q[i].val);
          default:     check(lvl_q[i].name, int'(pressed), lvl_q[i].val);
        endcase
        lvl_q.delete(i);
      end
    end
    if (done) begin
      check("pulse_queue_drained", pulse_q.size(), 0);
      check("level_queue_drained", lvl_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus (all changes on falling edges; a change at cyc=k is first
  // sampled at edge k+1, so a clean press strobes at cyc k+8).
  // ---------------------------------------------------------------------------
  initial begin
    int k;
    int m;
    int r;

    // Reset state
    step(2);
    expect_lvl(cyc + 1, SIG_COUNT,   0, "reset_count");
    expect_lvl(cyc + 1, SIG_PULSE,   0, "reset_pulse");
    expect_lvl(cyc + 1, SIG_PRESSED, 0, "reset_pressed");
    step(1);
    rst_n = 1'b1;
    step(3);

    // Clean press and release
    k = cyc;
    btn = 1'b1;
    expect_pulse(k + 8, 1);
    expect_lvl(k + 7, SIG_PRESSED, 0, "clean_pressed_before");
    expect_lvl(k + 8, SIG_PRESSED, 1, "clean_pressed_at");
    expect_lvl(k + 8, SIG_COUNT,   1, "clean_count");
    step(12);
    m = cyc;
    btn = 1'b0;
    expect_lvl(m + 7, SIG_PRESSED, 1, "release_pressed_before");
    expect_lvl(m + 8, SIG_PRESSED, 0, "release_pressed_at");
    expect_lvl(m + 8, SIG_COUNT,   1, "release_count");
    step(12);

    // Bounce: 1,0,1,0 every 2 cycles, then hold 1
    for (int i = 0; i < 2; i++) begin
      btn = 1'b1;
      step(2);
      btn = 1'b0;
      step(2);
    end
    k = cyc;
    btn = 1'b1;
    expect_pulse(k + 8, 2);
    expect_lvl(k + 7, SIG_COUNT, 1, "bounce_count_before");
    expect_lvl(k + 8, SIG_COUNT, 2, "bounce_count_at");
    step(12);
    btn = 1'b0;
    step(12);

    // Glitch of 4 cycles while released: ignored
    btn = 1'b1;
    step(4);
    btn = 1'b0;
    step(12);
    expect_lvl(cyc + 1, SIG_COUNT,   2, "glitch_count");
    expect_lvl(cyc + 1, SIG_PRESSED, 0, "glitch_pressed");
    step(2);

    // Clear, then 256 presses wrap back to 0
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    expect_lvl(cyc + 1, SIG_COUNT, 0, "clr_count");
    step(2);
    for (int i = 0; i < 256; i++) begin
      k = cyc;
      btn = 1'b1;
      expect_pulse(k + 8, (i + 1) % 256);
      step(10);
      btn = 1'b0;
      step(10);
    end
    expect_lvl(cyc + 1, SIG_COUNT, 0, "wrap_count");
    step(2);

    // clr on the same edge as an increment: count 0, strobe still fires
    k = cyc;
    btn = 1'b1;
    expect_pulse(k + 8, 0);
    expect_lvl(k + 8, SIG_PULSE, 1, "clr_coincide_pulse");
    step(7);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    expect_lvl(cyc + 2, SIG_COUNT,   0, "clr_coincide_count_after");
    expect_lvl(cyc + 2, SIG_PRESSED, 1, "clr_coincide_fsm_unaffected");
    step(10);
    btn = 1'b0;
    step(12);

    // One clean press so the reset below has something to clear
    k = cyc;
    btn = 1'b1;
    expect_pulse(k + 8, 1);
    step(10);
    btn = 1'b0;
    step(12);

    // Reset during PRESS_WAIT (entered at edge k+3), button kept held
    k = cyc;
    btn = 1'b1;
    step(4);
    rst_n = 1'b0;
    expect_lvl(k + 5, SIG_COUNT,   0, "midreset_count");
    expect_lvl(k + 5, SIG_PULSE,   0, "midreset_pulse");
    expect_lvl(k + 5, SIG_PRESSED, 0, "midreset_pressed");
    step(3);
    // Held through release: first non-reset edge is r+1, strobe 7 edges later
    r = cyc;
    rst_n = 1'b1;
    expect_pulse(r + 8, 1);
    expect_lvl(r + 7, SIG_PRESSED, 0, "held_reset_pressed_before");
    expect_lvl(r + 8, SIG_PRESSED, 1, "held_reset_pressed_at");
    expect_lvl(r + 8, SIG_COUNT,   1, "held_reset_count");
    step(12);
    btn = 1'b0;
    step(12);

    // Long hold of 1200 cycles
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    k = cyc;
    btn = 1'b1;
    expect_pulse(k + 8, 1);
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
    expect_pulse(k + 508,  2);
    expect_pulse(k + 758,  3);
    expect_pulse(k + 1008, 4);
`endif
    step(1200);
    btn = 1'b0;
    step(12);
`ifdef BUTTON_COUNTER_AUTOREPEAT_EN
    expect_lvl(cyc + 1, SIG_COUNT, 4, "hold_count");
`else
    expect_lvl(cyc + 1, SIG_COUNT, 1, "hold_count");
`endif
    expect_lvl(cyc + 1, SIG_PRESSED, 0, "hold_released");
    step(8);

    done = 1'b1;
  end

endmodule
